serial_add_seq: RTL and testbench

Bit-serial adder sequencer: accepts two WIDTH-bit operands and a carry-in on a start handshake, then sums them LSB-first over WIDTH clocks. Each cycle it feeds one bit pair plus the stored carry through a single 1-bit full-adder cell (fulladd), so one full adder is time-shared across the whole word. It sits between a requester (control logic or testbench) and the full-adder datapath cell, and returns a registered WIDTH-bit sum, carry-out and a one-cycle done pulse.

---
 rtl/serial_add_seq.sv | 181 ++++++++++++++++++
 tb/tb_serial_add_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// -----------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial adder sequencer. Captures two WIDTH-bit operands and a carry-in
// on an accepted start, then walks the word LSB-first through one shared
// 1-bit full-adder cell, one bit per clock. The completed sum and carry-out
// are registered and held until the next completion.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request; accepted only in IDLE or DONE
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   ci     in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while the word is being processed (RUN)
//   done   out  1      one-cycle pulse when a new result is available (DONE)
//   s      out  WIDTH  registered sum of the last completed operation
//   co     out  1      registered carry-out of the last completed operation
// -----------------------------------------------------------------------------

// Single-bit full-adder cell, time-shared by the sequencer.
module fulladd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             load_s;
    logic             last_s;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic             c_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] s_r;
    logic             co_r;

    logic             fs_s;
    logic             fc_s;

    // The one full-adder cell: LSBs of the operand shifters plus stored carry.
    fulladd u_fa (
        .a  (sa_r[0]),
        .b  (sb_r[0]),
        .ci (c_r),
        .s  (fs_s),
        .co (fc_s)
    );

    // Final bit of the word is being processed on this edge.
    assign last_s = (state_r == RUN) && (cnt_r == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and operand-load request.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                // start is deliberately ignored here; operands are not re-sampled.
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                // Back-to-back accept: no IDLE gap, done still pulses this cycle.
                if (start) begin
                    state_nxt_s = RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                load_s      = 1'b0;
            end
        endcase
    end

    // Operand shifters, carry flop, partial-sum shifter and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_r  <= {WIDTH{1'b0}};
            sb_r  <= {WIDTH{1'b0}};
            c_r   <= 1'b0;
            acc_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            sa_r  <= a;
            sb_r  <= b;
            c_r   <= ci;
            acc_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (state_r == RUN) begin
            // Sum bits enter at the MSB so bit 0 lands at acc[0] after WIDTH shifts.
            acc_r <= {fs_s, acc_r[WIDTH-1:1]};
            sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
            c_r   <= fc_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            sa_r  <= sa_r;
            sb_r  <= sb_r;
            c_r   <= c_r;
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers: updated only when the last bit completes, so the
    // previous result stays visible throughout a following run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r  <= {WIDTH{1'b0}};
            co_r <= 1'b0;
        end else if (last_s) begin
            s_r  <= {fs_s, acc_r[WIDTH-1:1]};
            co_r <= fc_s;
        end else begin
            s_r  <= s_r;
            co_r <= co_r;
        end
    end

    assign busy = (state_r == RUN);
    assign done = (state_r == DONE);
    assign s    = s_r;
    assign co   = co_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// -----------------------------------------------------------------------------
// tb_serial_add_seq
//
// Directed bench for serial_add_seq (WIDTH=8). Inputs are driven and outputs
// sampled on the falling clock edge; expected sums are hand-computed.
// -----------------------------------------------------------------------------
module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         co;

    int pass_cnt;
    int chk_cnt;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drive a start request for the coming rising edge (call at a falling edge).
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
        start = 1'b1;
        a     = av;
        b     = bv;
        ci    = civ;
    endtask

    // Follow one operation after launch(): latency, busy length, held previous
    // result during the run, final result, and single done pulse. Optionally
    // pokes start mid-run, or chains a back-to-back request in the DONE cycle.
    task automatic finish_op(input string tag,
                             input logic [W-1:0] exp_s, input logic exp_co,
                             input logic [W-1:0] prev_s, input logic prev_co,
                             input bit mid_start, input bit b2b,
                             input logic [W-1:0] na, input logic [W-1:0] nb, input logic nci);
        int cycles;
        int busy_cycles;
        bit stable;
        bit seen_done;
        cycles      = 0;
        busy_cycles = 0;
        stable      = 1'b1;
        seen_done   = 1'b0;
        while (!seen_done && cycles < 30) begin
            @(negedge clk);
            cycles = cycles + 1;
            start  = 1'b0;
            if (mid_start && cycles >= 2 && cycles <= 5) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
            end
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (busy) busy_cycles = busy_cycles + 1;
                if (s !== prev_s || co !== prev_co) stable = 1'b0;
            end
        end
        check({tag, "_latency"}, cycles, 32'd9);
        check({tag, "_busy_len"}, busy_cycles, 32'd8);
        check({tag, "_held"}, {31'd0, stable}, 32'd1);
        check({tag, "_s"}, {24'd0, s}, {24'd0, exp_s});
        check({tag, "_co"}, {31'd0, co}, {31'd0, exp_co});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        if (b2b) begin
            launch(na, nb, nci);
        end else begin
            @(negedge clk);
            check({tag, "_done_once"}, {31'd0, done}, 32'd0);
            check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        ci    = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_s", {24'd0, s}, 32'd0);
        check("rst_co", {31'd0, co}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0x5A + 0x3C = 0x096
        launch(8'h5A, 8'h3C, 1'b0);
        finish_op("basic", 8'h96, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Full carry ripple: 0xFF + 0x01 = 0x100, 0xFF + 0x00 + 1 = 0x100
        launch(8'hFF, 8'h01, 1'b0);
        finish_op("wrap1", 8'h00, 1'b1, 8'h96, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'hFF, 8'h00, 1'b1);
        finish_op("wrap2", 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // start held mid-run with other operands is ignored: 0x12 + 0x34 = 0x46
        launch(8'h12, 8'h34, 1'b0);
        finish_op("ignore", 8'h46, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // 0x0F + 0x01 = 0x10, then 0xAA + 0x55 = 0xFF with 0x10 held meanwhile;
        // back-to-back start in DONE: 0x80 + 0x80 + 1 = 0x101
        launch(8'h0F, 8'h01, 1'b0);
        finish_op("hold_a", 8'h10, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        launch(8'hAA, 8'h55, 1'b0);
        finish_op("hold_b", 8'hFF, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80, 1'b1);
        finish_op("b2b", 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a run.
        launch(8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_s", {24'd0, s}, 32'd0);
        check("arst_co", {31'd0, co}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        launch(8'h5A, 8'h3C, 1'b0);
        finish_op("after_rst", 8'h96, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
